mux3_port_arbiter: RTL

//   Round-robin/fixed-priority arbiter sharing one 3-input-muxed resource (memory/bus port)

---
 rtl/mux3_port_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mux3_port_arbiter.sv
// Arbiter sharing one 3-to-1 muxed resource port among fetch, load/store and debug/DMA requesters.
// Grants are held until done_i or a BUSY-cycle timeout; a one-cycle IDLE bubble separates grants.
module mux3_port_arbiter #(
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] req_i,
    input  logic       done_i,
    output logic [2:0] gnt_o,
    output logic [1:0] sel_o,
    output logic       mem_en_o,
    output logic       err_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state, state_nx;
    logic [1:0]       ptr, ptr_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       gnt_nx;
    logic [1:0]       sel_nx;
    logic             en_nx;
    logic             err_nx;
    logic [1:0]       winner;
    logic [1:0]       ptr_after;

    // Winner selection: fixed priority or round-robin starting at ptr.
    always_comb begin
        winner = 2'd0;
        if (PRIO_MODE != 0) begin
            if (req_i[0])      winner = 2'd0;
            else if (req_i[1]) winner = 2'd1;
            else if (req_i[2]) winner = 2'd2;
        end else begin
            case (ptr)
                2'd1: begin
                    if (req_i[1])      winner = 2'd1;
                    else if (req_i[2]) winner = 2'd2;
                    else if (req_i[0]) winner = 2'd0;
                end
                2'd2: begin
                    if (req_i[2])      winner = 2'd2;
                    else if (req_i[0]) winner = 2'd0;
                    else if (req_i[1]) winner = 2'd1;
                end
                default: begin
                    if (req_i[0])      winner = 2'd0;
                    else if (req_i[1]) winner = 2'd1;
                    else if (req_i[2]) winner = 2'd2;
                end
            endcase
        end
    end

    // sel_o holds the current owner while BUSY, so the next pointer follows it.
    assign ptr_after = (sel_o == 2'd2) ? 2'd0 : sel_o + 2'd1;

    // Next-state and next-output logic.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        gnt_nx   = gnt_o;
        sel_nx   = sel_o;
        en_nx    = mem_en_o;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (req_i != 3'b000) begin
                    state_nx = BUSY;
                    gnt_nx   = 3'b001 << winner;
                    sel_nx   = winner;
                    en_nx    = 1'b1;
                    cnt_nx   = '0;
                end
            end
            BUSY: begin
                if (done_i || (cnt == CNT_LAST)) begin
                    state_nx = IDLE;
                    gnt_nx   = 3'b000;
                    en_nx    = 1'b0;
                    cnt_nx   = '0;
                    ptr_nx   = ptr_after;
                    err_nx   = ~done_i;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = 3'b000;
                en_nx    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            cnt      <= '0;
            gnt_o    <= 3'b000;
            sel_o    <= 2'd0;
            mem_en_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            cnt      <= cnt_nx;
            gnt_o    <= gnt_nx;
            sel_o    <= sel_nx;
            mem_en_o <= en_nx;
            err_o    <= err_nx;
        end
    end

endmodule
